sw_input_conditioner: RTL and testbench

//  Front end between the board switches and the picoMIPS core.
//  - Synchronises the raw data switches and the go switch, then debounces go.
//  - On a debounced go press, captures an 8-bit operand and presents it to the

---
 rtl/sw_input_conditioner_if.sv | 26 ++
 rtl/sw_input_conditioner.sv | 127 ++++++++++++
 tb/tb_sw_input_conditioner.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sw_input_conditioner_if.sv
`default_nettype none
// ============================================================================
// Module      : sw_input_conditioner_if
// Description : Operand valid/ack handshake between switch front end and core.
// Revision    : 1.0 - initial release
// ============================================================================
interface sw_input_conditioner_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ack;

  modport master (
    output data_out,
    output data_valid,
    input  data_ack
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ack
  );
endinterface
`default_nettype wire

// File: rtl/sw_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : sw_input_conditioner
// Description : Synchronise + debounce board switches, one operand per press.
// Revision    : 1.0 - initial release
// ============================================================================
module sw_input_conditioner #(
  parameter int DATA_W          = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  n_reset,
  input  logic [DATA_W-1:0]     sw_data_raw,
  input  logic                  sw_go_raw,
  sw_input_conditioner_if.master bus,
  output logic                  go_level,
  output logic                  overrun
);

  localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  localparam logic [1:0] c_ST_IDLE    = 2'd0;
  localparam logic [1:0] c_ST_HOLD    = 2'd1;
  localparam logic [1:0] c_ST_RELEASE = 2'd2;

  logic [SYNC_STAGES-1:0][DATA_W:0] r_sync;
  logic [c_CNT_W-1:0]               r_cnt;
  logic                             r_go_level;
  logic                             r_go_level_q;
  logic [DATA_W-1:0]                r_data;
  logic                             r_overrun;
  logic [1:0]                       r_state;
  logic [1:0]                       w_state_nxt;

  logic                             w_go_sync;
  logic [DATA_W-1:0]                w_data_sync;
  logic [c_CNT_W-1:0]               w_cnt_inc;
  logic                             w_go_rise;
  logic                             w_valid;
  logic                             w_capture;
  logic                             w_ovr_set;

  // Go and data share one chain so they are delayed identically.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], {sw_go_raw, sw_data_raw}};
    end
  end

  assign w_go_sync   = r_sync[SYNC_STAGES-1][DATA_W];
  assign w_data_sync = r_sync[SYNC_STAGES-1][DATA_W-1:0];
  assign w_cnt_inc   = r_cnt + c_CNT_ONE;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_cnt        <= '0;
      r_go_level   <= 1'b0;
      r_go_level_q <= 1'b0;
    end else begin
      r_go_level_q <= r_go_level;
      if (w_go_sync == r_go_level) begin
        r_cnt <= '0;
      end else if (w_cnt_inc == c_CNT_MAX) begin
        r_go_level <= ~r_go_level;
        r_cnt      <= '0;
      end else begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign w_go_rise = r_go_level & ~r_go_level_q;

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_state <= c_ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_ST_IDLE:    if (w_go_rise)   w_state_nxt = c_ST_HOLD;
      c_ST_HOLD:    if (bus.data_ack) w_state_nxt = r_go_level ? c_ST_RELEASE : c_ST_IDLE;
      c_ST_RELEASE: if (!r_go_level) w_state_nxt = c_ST_IDLE;
      default:                       w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_comb begin
    w_valid   = 1'b0;
    w_capture = 1'b0;
    w_ovr_set = 1'b0;
    case (r_state)
      c_ST_IDLE: w_capture = w_go_rise;
      c_ST_HOLD: begin
        w_valid   = 1'b1;
        w_ovr_set = w_go_rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_reset) begin
      r_data    <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_capture) r_data <= w_data_sync;
      if (w_ovr_set) r_overrun <= 1'b1;
    end
  end

  assign bus.data_out   = r_data;
  assign bus.data_valid = w_valid;
  assign go_level       = r_go_level;
  assign overrun        = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_sw_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_sw_input_conditioner
// Description : Directed self-checking bench for sw_input_conditioner.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sw_input_conditioner;

  localparam int c_DATA_W = 8;

  logic                clk;
  logic                n_reset;
  logic [c_DATA_W-1:0] sw_data_raw;
  logic                sw_go_raw;
  logic                go_level;
  logic                overrun;

  int n_checks;
  int n_errors;

  sw_input_conditioner_if #(.DATA_W(c_DATA_W)) bus ();

  sw_input_conditioner #(
    .DATA_W          (c_DATA_W),
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (4)
  ) u_dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .sw_data_raw (sw_data_raw),
    .sw_go_raw   (sw_go_raw),
    .bus         (bus.master),
    .go_level    (go_level),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Caller has just changed the stimulus that starts a press; the first edge
  // after this call is edge 1 and valid must appear after edge 7, not 6.
  task automatic latency_check(input string tag, input logic [7:0] exp_data);
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      if (i == 6) begin
        check({tag, "_valid_e6"}, 32'(bus.data_valid), 32'd0);
        check({tag, "_level_e6"}, 32'(go_level), 32'd1);
      end
      if (i == 7) begin
        check({tag, "_valid_e7"}, 32'(bus.data_valid), 32'd1);
        check({tag, "_data"}, 32'(bus.data_out), 32'(exp_data));
      end
    end
  endtask

  task automatic ack_pulse();
    bus.data_ack = 1'b1;
    tick(1);
    bus.data_ack = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;

    // T1 reset with every input high
    n_reset      = 1'b0;
    sw_data_raw  = 8'hFF;
    sw_go_raw    = 1'b1;
    bus.data_ack = 1'b1;
    tick(2);
    check("t1_valid", 32'(bus.data_valid), 32'd0);
    check("t1_data", 32'(bus.data_out), 32'd0);
    check("t1_level", 32'(go_level), 32'd0);
    check("t1_overrun", 32'(overrun), 32'd0);

    sw_go_raw    = 1'b0;
    bus.data_ack = 1'b0;
    sw_data_raw  = 8'h02;
    n_reset      = 1'b1;
    tick(10);
    check("t1_idle_valid", 32'(bus.data_valid), 32'd0);
    check("t1_idle_level", 32'(go_level), 32'd0);

    // T2 clean press
    sw_go_raw = 1'b1;
    latency_check("t2", 8'h02);
    ack_pulse();
    check("t2_ack_valid", 32'(bus.data_valid), 32'd0);
    tick(10);
    check("t2_held_no_valid", 32'(bus.data_valid), 32'd0);
    sw_go_raw = 1'b0;
    tick(10);
    check("t2_rel_level", 32'(go_level), 32'd0);
    check("t2_rel_valid", 32'(bus.data_valid), 32'd0);

    // T3 bounce then steady high
    for (int i = 0; i < 6; i++) begin
      sw_go_raw = (i % 2 == 0);
      tick(1);
      check("t3_bounce_valid", 32'(bus.data_valid), 32'd0);
    end
    tick(2);
    check("t3_bounce_level", 32'(go_level), 32'd0);
    check("t3_bounce_valid2", 32'(bus.data_valid), 32'd0);
    sw_go_raw = 1'b1;
    latency_check("t3", 8'h02);

    // T4 data change while holding
    sw_data_raw = 8'hA5;
    tick(10);
    check("t4_hold_valid", 32'(bus.data_valid), 32'd1);
    check("t4_hold_data", 32'(bus.data_out), 32'h02);
    ack_pulse();
    check("t4_ack_valid", 32'(bus.data_valid), 32'd0);
    sw_go_raw = 1'b0;
    tick(10);
    sw_go_raw = 1'b1;
    latency_check("t4", 8'hA5);

    // T5 overrun: release and re-press with no ack
    check("t5_ovr_before", 32'(overrun), 32'd0);
    sw_data_raw = 8'h5A;
    sw_go_raw   = 1'b0;
    tick(10);
    check("t5_rel_valid", 32'(bus.data_valid), 32'd1);
    sw_go_raw = 1'b1;
    tick(10);
    check("t5_ovr_set", 32'(overrun), 32'd1);
    check("t5_ovr_data", 32'(bus.data_out), 32'hA5);
    check("t5_ovr_valid", 32'(bus.data_valid), 32'd1);
    ack_pulse();
    check("t5_ack_valid", 32'(bus.data_valid), 32'd0);
    tick(10);
    check("t5_release_wait", 32'(bus.data_valid), 32'd0);
    sw_go_raw = 1'b0;
    tick(10);
    sw_go_raw = 1'b1;
    latency_check("t5", 8'h5A);
    check("t5_ovr_sticky", 32'(overrun), 32'd1);

    // T6 reset in the middle of a hold, go still high
    n_reset = 1'b0;
    tick(2);
    check("t6_rst_valid", 32'(bus.data_valid), 32'd0);
    check("t6_rst_data", 32'(bus.data_out), 32'd0);
    check("t6_rst_overrun", 32'(overrun), 32'd0);
    check("t6_rst_level", 32'(go_level), 32'd0);
    n_reset = 1'b1;
    latency_check("t6", 8'h5A);
    check("t6_ovr_clear", 32'(overrun), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
